// File: rtl/jtdd2_snd_cmd.sv
`default_nettype none
// ============================================================================
//  Module   : jtdd2_snd_cmd
//  Purpose  : Sound-side receiver for the main-CPU command channel. Captures
//             each rising edge of snd_irq together with snd_latch into a small
//             FIFO, presents the head byte to the sound CPU, issues one timed
//             NMI pulse per queued command and pops on sound CPU reads.
//  Revision : 1.0  initial release
// ============================================================================
module jtdd2_snd_cmd #(
    parameter int AW      = 2,
    parameter int NMI_LEN = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          snd_irq,
    input  logic [7:0]    snd_latch,
    input  logic          cpu_rd,
    input  logic          ovf_clr,
    output logic [7:0]    dout,
    output logic          nmi,
    output logic [AW:0]   count,
    output logic          ovf
);

    localparam int          c_DEPTH     = 2**AW;
    localparam logic [AW:0] c_FULL      = (AW+1)'(c_DEPTH);
    localparam logic [3:0]  c_TICK_LAST = 4'(NMI_LEN-1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_WAIT   = 2'd2
    } t_state;

    // ------------------------------------------------------------------
    // Storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [c_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic [7:0]    r_last;
    logic          r_ovf;
    logic          r_irq_l;

    t_state        r_state;
    t_state        w_state_nxt;
    logic [3:0]    r_tick;
    logic [3:0]    w_tick_nxt;
    logic          w_nmi;

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_wr_en;
    logic          w_drop;

    // Edge detect runs on every clk so short strobes are never missed.
    assign w_push  = snd_irq & ~r_irq_l;
    assign w_pop   = cpu_rd & cen & (r_count != '0);
    assign w_full  = (r_count == c_FULL);
    // A same-cycle pop frees the slot the push needs, even when full.
    assign w_wr_en = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    // Previous strobe level; resets high so a strobe already high at
    // reset release is not taken as a command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_l <= 1'b1;
        end else begin
            r_irq_l <= snd_irq;
        end
    end

    // FIFO data array; contents are only observed through count-guarded reads.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr] <= snd_latch;
        end
    end

    // Pointers, occupancy and the last value handed to the sound CPU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_last  <= 8'h00;
        end else begin
            if (w_wr_en) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd   <= r_rd + 1'b1;
                r_last <= r_mem[r_rd];
            end
            if (w_wr_en && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr_en && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // NMI sequencer: one pulse per command, re-armed after each pop.
    // ------------------------------------------------------------------

    // State and tick registers; async reset drops nmi immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_tick  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    // Next-state and pulse output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_nmi       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = ST_ASSERT;
                    w_tick_nxt  = 4'd0;
                end
            end
            ST_ASSERT: begin
                w_nmi = 1'b1;
                if (w_pop) begin
                    w_state_nxt = ST_IDLE;
                end else if (cen) begin
                    if (r_tick == c_TICK_LAST) begin
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_tick_nxt = r_tick + 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (w_pop) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dout  = (r_count != '0) ? r_mem[r_rd] : r_last;
    assign nmi   = w_nmi;
    assign count = r_count;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_jtdd2_snd_cmd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtdd2_snd_cmd
//  Purpose  : Directed self-checking bench for jtdd2_snd_cmd with a byte
//             queue model of the command FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jtdd2_snd_cmd;

    logic       clk;
    logic       rst_n;
    logic       cen;
    logic       snd_irq;
    logic [7:0] snd_latch;
    logic       cpu_rd;
    logic       ovf_clr;
    logic [7:0] dout;
    logic       nmi;
    logic [2:0] count;
    logic       ovf;

    int         n_checks = 0;
    int         n_errors = 0;
    int         pulses   = 0;
    int         nmi_ticks = 0;
    logic       nmi_q    = 1'b0;
    logic       cen_div  = 1'b0;

    logic [7:0] q[$];
    logic [7:0] exp_last = 8'h00;
    logic       exp_ovf  = 1'b0;

    jtdd2_snd_cmd #(.AW(2), .NMI_LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .snd_irq   (snd_irq),
        .snd_latch (snd_latch),
        .cpu_rd    (cpu_rd),
        .ovf_clr   (ovf_clr),
        .dout      (dout),
        .nmi       (nmi),
        .count     (count),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cen changes shortly after the rising edge, so it is stable at both edges.
    initial begin
        cen = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            cen = cen_div ? ~cen : 1'b1;
        end
    end

    // Pulse and tick monitor, sampling pre-edge values.
    always @(posedge clk) begin
        if (nmi && cen) nmi_ticks++;
        if (nmi && !nmi_q) pulses++;
        nmi_q = nmi;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Model push: accepted unless the queue is full.
    task automatic model_push(input logic [7:0] b);
        if (q.size() < 4) q.push_back(b);
        else exp_ovf = 1'b1;
    endtask

    task automatic strobe(input logic [7:0] b);
        snd_latch = b;
        snd_irq   = 1'b1;
        model_push(b);
        step();
        snd_irq   = 1'b0;
        step();
    endtask

    task automatic do_read(input string tag);
        int k = 0;
        while (!cen && k < 10) begin step(); k++; end
        if (q.size() != 0) begin
            chk(tag, 32'(dout), 32'(q[0]));
            exp_last = q.pop_front();
        end
        cpu_rd = 1'b1;
        step();
        cpu_rd = 1'b0;
    endtask

    task automatic wait_pulses(input int target, input string tag);
        int k = 0;
        while ((pulses < target || nmi) && k < 400) begin step(); k++; end
        chk(tag, 32'(k < 400), 32'd1);
    endtask

    initial begin
        int p0;
        int t0;
        rst_n = 1'b0; snd_irq = 1'b0; snd_latch = 8'h00; cpu_rd = 1'b0; ovf_clr = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_dout",  32'(dout),  32'h00);
        chk("rst_nmi",   32'(nmi),   32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_ovf",   32'(ovf),   32'h0);

        // Single command with latency and pulse width
        p0 = pulses; t0 = nmi_ticks;
        snd_latch = 8'h3A; snd_irq = 1'b1; model_push(8'h3A);
        step();
        snd_irq = 1'b0;
        chk("single_count_n1", 32'(count), 32'd1);
        chk("single_dout_n1",  32'(dout),  32'h3A);
        chk("single_nmi_n1",   32'(nmi),   32'h0);
        step();
        chk("single_nmi_n2",   32'(nmi),   32'h1);
        wait_pulses(p0 + 1, "single_pulse_wait");
        chk("single_ticks",    32'(nmi_ticks - t0), 32'd4);
        do_read("single_read");
        chk("single_count_after", 32'(count), 32'd0);
        chk("single_dout_after",  32'(dout),  32'(exp_last));
        repeat (10) step();
        chk("single_no_repulse",  32'(pulses - p0), 32'd1);

        // Burst of five with divided cen; fifth is lost
        cen_div = 1'b1;
        p0 = pulses; t0 = nmi_ticks;
        for (int i = 1; i <= 5; i++) strobe(8'(i));
        chk("burst_count", 32'(count), 32'd4);
        chk("burst_ovf",   32'(ovf),   32'(exp_ovf));
        chk("burst_dout",  32'(dout),  32'h01);
        for (int i = 0; i < 4; i++) begin
            wait_pulses(p0 + i + 1, "burst_pulse_wait");
            do_read("burst_read");
        end
        repeat (20) step();
        chk("burst_pulses", 32'(pulses - p0), 32'd4);
        chk("burst_ticks",  32'(nmi_ticks - t0), 32'd16);
        chk("burst_empty",  32'(count), 32'd0);
        chk("burst_last",   32'(dout),  32'h04);
        ovf_clr = 1'b1; exp_ovf = 1'b0;
        step();
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 32'(exp_ovf));

        // Full FIFO with simultaneous push and pop
        cen_div = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 4; i++) strobe(8'h10 + 8'(i));
        chk("full_count", 32'(count), 32'd4);
        chk("full_head",  32'(dout),  32'(q[0]));
        exp_last = q.pop_front();
        q.push_back(8'h14);
        snd_latch = 8'h14; snd_irq = 1'b1; cpu_rd = 1'b1;
        step();
        snd_irq = 1'b0; cpu_rd = 1'b0;
        chk("pushpop_count", 32'(count), 32'd4);
        chk("pushpop_ovf",   32'(ovf),   32'h0);
        for (int i = 0; i < 4; i++) do_read("pushpop_read");
        chk("pushpop_empty", 32'(count), 32'd0);
        wait_pulses(pulses, "pushpop_settle");

        // Held strobe with a changing latch: exactly one push
        snd_latch = 8'h55; snd_irq = 1'b1; model_push(8'h55);
        step();
        for (int i = 0; i < 99; i++) begin
            snd_latch = 8'($urandom_range(0, 255));
            step();
        end
        snd_irq = 1'b0;
        step();
        chk("held_count", 32'(count), 32'd1);
        chk("held_dout",  32'(dout),  32'h55);
        wait_pulses(pulses, "held_settle");
        do_read("held_read");

        // Reset released while the strobe is high
        p0 = pulses;
        snd_irq = 1'b1; rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        q.delete(); exp_last = 8'h00;
        repeat (10) step();
        chk("rsthigh_count", 32'(count), 32'd0);
        chk("rsthigh_pulse", 32'(pulses - p0), 32'd0);
        snd_irq = 1'b0;
        step();

        // Reset asserted during an NMI pulse
        strobe(8'h22);
        chk("midpulse_nmi_before", 32'(nmi), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midpulse_nmi_async", 32'(nmi),   32'h0);
        chk("midpulse_count",     32'(count), 32'd0);
        q.delete(); exp_last = 8'h00;
        step();
        rst_n = 1'b1;
        step();
        chk("midpulse_dout", 32'(dout), 32'(exp_last));

        // Read while empty with a same-cycle strobe
        snd_latch = 8'h7F; snd_irq = 1'b1; cpu_rd = 1'b1; model_push(8'h7F);
        step();
        snd_irq = 1'b0; cpu_rd = 1'b0;
        chk("emptyrd_count", 32'(count), 32'd1);
        chk("emptyrd_dout",  32'(dout),  32'h7F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
